// File: rtl/midterm_alu_arbiter.sv
// midterm_alu_arbiter
//   Round-robin arbiter/sequencer that shares one ALU between two requesters.
//   One operation is accepted at a time. Its operands are driven to the ALU from
//   registers for ALU_LAT cycles. The result and flags are then captured and
//   returned with the requester ID on a valid/ready response channel.
//
//   Optional feature macro: ALU_ARB_OPCHECK_EN
//     When defined, illegal opcode/mode combinations are rejected at acceptance.
//     They never reach the ALU, and an error response is returned in the next cycle.
//
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   req{0,1}_valid/_ready           request handshake (ready is combinational)
//   req{0,1}_op1/_op2/_opsel/_mode  request payload
//   alu_op1/_op2/_opsel/_mode       registered drive to the shared ALU
//   alu_result, alu_c/z/o/s         ALU outputs
//   rsp_valid/_ready                response handshake
//   rsp_id, rsp_result, rsp_c/z/o/s, rsp_err  response payload
//   busy                            FSM not idle
module midterm_alu_arbiter #(
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [2:0]       req0_opsel,
  input  logic             req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [2:0]       req1_opsel,
  input  logic             req1_mode,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [2:0]       alu_opsel,
  output logic             alu_mode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             alu_o,
  input  logic             alu_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_c,
  output logic             rsp_z,
  output logic             rsp_o,
  output logic             rsp_s,
  output logic             rsp_err,
  output logic             busy
);

  // Four bits cover the legal ALU_LAT range of 1..15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [2:0]       opsel;
    logic             mode;
  } op_t;

  state_t           state, state_next;
  logic             rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             grant;
  logic             accept;
  logic             capture;
  logic             transfer;
  logic             illegal;
  op_t              sel_op;

  // Sole valid requester wins; on contention rr_ptr decides.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = rr_ptr;
    else if (req1_valid)          grant = 1'b1;
  end

  // The reset gate keeps ready low while reset is held, even though state is already IDLE.
  assign accept     = (state == S_IDLE) && !reset && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept &&  grant;

  assign sel_op = grant ? {req1_op1, req1_op2, req1_opsel, req1_mode}
                        : {req0_op1, req0_op2, req0_opsel, req0_mode};

`ifdef ALU_ARB_OPCHECK_EN
  // Arithmetic has no opcode 7; logic mode only defines opcodes 0..4.
  assign illegal = (!sel_op.mode && (sel_op.opsel == 3'b111)) ||
                   ( sel_op.mode && (sel_op.opsel >  3'b100));
`else
  assign illegal = 1'b0;
`endif

  assign capture  = (state == S_WAIT) && (cnt == CNT_W'(1));
  assign transfer = (state == S_RESP) && rsp_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (accept)   state_next = illegal ? S_RESP : S_WAIT;
      S_WAIT:  if (capture)  state_next = S_RESP;
      S_RESP:  if (transfer) state_next = S_IDLE;
      default:               state_next = S_IDLE;
    endcase
  end

  // Datapath: ALU drive, settle counter, response capture, round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rr_ptr     <= 1'b0;
      cnt        <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_opsel  <= '0;
      alu_mode   <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_c      <= 1'b0;
      rsp_z      <= 1'b0;
      rsp_o      <= 1'b0;
      rsp_s      <= 1'b0;
    end else begin
      busy      <= (state_next != S_IDLE);
      rsp_valid <= (state_next == S_RESP);
      if (state == S_WAIT) cnt <= cnt - CNT_W'(1);
      if (accept) begin
        rsp_id <= grant;
        cnt    <= CNT_W'(ALU_LAT);
        // Rejected ops leave the ALU inputs untouched.
        if (!illegal) begin
          alu_op1   <= sel_op.op1;
          alu_op2   <= sel_op.op2;
          alu_opsel <= sel_op.opsel;
          alu_mode  <= sel_op.mode;
        end else begin
          rsp_result <= '0;
          rsp_c      <= 1'b0;
          rsp_z      <= 1'b0;
          rsp_o      <= 1'b0;
          rsp_s      <= 1'b0;
        end
      end
      if (capture) begin
        rsp_result <= alu_result;
        rsp_c      <= alu_c;
        rsp_z      <= alu_z;
        rsp_o      <= alu_o;
        rsp_s      <= alu_s;
      end
      // Hand priority to the requester that was not just served.
      if (transfer) rr_ptr <= ~rsp_id;
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  // Error flag for rejected ops; cleared by every legal acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rsp_err <= 1'b0;
    else if (accept) rsp_err <= illegal;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_midterm_alu_arbiter.sv
`timescale 1ns/1ps
module tb_midterm_alu_arbiter;

  localparam int unsigned W     = 128;
  localparam int unsigned LAT   = 1;
  localparam int unsigned LAT_B = 4;
  localparam int unsigned CW    = W + 6;

  typedef struct packed {
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [2:0]   opsel;
    logic         mode;
  } pay_t;

  // Behavioural stand-in for the shared ALU: returns {c, z, o, s, result}.
  function automatic logic [W+3:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] opsel, input logic mode);
    logic [W:0]   wide;
    logic [W-1:0] r;
    logic         c, o;
    c = 1'b0; o = 1'b0; r = '0;
    if (!mode) begin
      case (opsel)
        3'd0: begin
          wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; c = wide[W];
          o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        3'd1: begin
          wide = {1'b0, a} - {1'b0, b}; r = wide[W-1:0]; c = wide[W];
          o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
        default: r = a + W'(opsel);
      endcase
    end else begin
      case (opsel)
        3'd0:    r = a & b;
        3'd1:    r = a | b;
        3'd2:    r = a ^ b;
        3'd3:    r = ~a;
        default: r = b;
      endcase
    end
    return {c, (r == '0), o, r[W-1], r};
  endfunction

  function automatic bit is_illegal(input pay_t p);
`ifdef ALU_ARB_OPCHECK_EN
    return (!p.mode && p.opsel == 3'd7) || (p.mode && p.opsel > 3'd4);
`else
    return (p.opsel != p.opsel);
`endif
  endfunction

  function automatic pay_t rand_pay();
    pay_t p;
    p.op1   = {$urandom, $urandom, $urandom, $urandom};
    p.op2   = {$urandom, $urandom, $urandom, $urandom};
    p.opsel = 3'($urandom_range(0, 7));
    p.mode  = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       p.op2 = p.op1;
      1:       p.op1 = '0;
      default: ;
    endcase
    return p;
  endfunction

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main DUT (ALU_LAT = 1)
  logic         req0_valid, req1_valid, req0_ready, req1_ready, rsp_ready;
  pay_t         p0, p1;
  logic [W-1:0] alu_op1, alu_op2, alu_result, rsp_result;
  logic [2:0]   alu_opsel;
  logic         alu_mode, alu_c, alu_z, alu_o, alu_s;
  logic         rsp_valid, rsp_id, rsp_c, rsp_z, rsp_o, rsp_s, rsp_err, busy;

  assign {alu_c, alu_z, alu_o, alu_s, alu_result} = alu_fn(alu_op1, alu_op2, alu_opsel, alu_mode);

  midterm_alu_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(p0.op1), .req0_op2(p0.op2), .req0_opsel(p0.opsel), .req0_mode(p0.mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(p1.op1), .req1_op2(p1.op2), .req1_opsel(p1.opsel), .req1_mode(p1.mode),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opsel(alu_opsel), .alu_mode(alu_mode),
    .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z), .alu_o(alu_o), .alu_s(alu_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_o(rsp_o), .rsp_s(rsp_s), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Second DUT (ALU_LAT = 4), req0 only, response always accepted
  logic         b_v0, b_r0, b_r1;
  pay_t         b_pay;
  logic [W-1:0] b_alu_op1, b_alu_op2, b_alu_result, b_rsp_result;
  logic [2:0]   b_alu_opsel;
  logic         b_alu_mode, b_alu_c, b_alu_z, b_alu_o, b_alu_s;
  logic         b_rsp_valid, b_rsp_id, b_rsp_c, b_rsp_z, b_rsp_o, b_rsp_s, b_rsp_err, b_busy;

  assign {b_alu_c, b_alu_z, b_alu_o, b_alu_s, b_alu_result} =
      alu_fn(b_alu_op1, b_alu_op2, b_alu_opsel, b_alu_mode);

  midterm_alu_arbiter #(.WIDTH(W), .ALU_LAT(LAT_B)) u_dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(b_v0), .req0_ready(b_r0),
    .req0_op1(b_pay.op1), .req0_op2(b_pay.op2), .req0_opsel(b_pay.opsel), .req0_mode(b_pay.mode),
    .req1_valid(1'b0), .req1_ready(b_r1),
    .req1_op1('0), .req1_op2('0), .req1_opsel(3'b000), .req1_mode(1'b0),
    .alu_op1(b_alu_op1), .alu_op2(b_alu_op2), .alu_opsel(b_alu_opsel), .alu_mode(b_alu_mode),
    .alu_result(b_alu_result), .alu_c(b_alu_c), .alu_z(b_alu_z), .alu_o(b_alu_o), .alu_s(b_alu_s),
    .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_id(b_rsp_id), .rsp_result(b_rsp_result),
    .rsp_c(b_rsp_c), .rsp_z(b_rsp_z), .rsp_o(b_rsp_o), .rsp_s(b_rsp_s), .rsp_err(b_rsp_err),
    .busy(b_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: one op in flight, response due LAT+1 cycles after acceptance.
  int          cyc = 0;
  bit          m_out;
  int          m_resp_at;
  bit          m_prio;
  logic [CW-1:0] m_exp;
  pay_t        m_alu;
  bit          acc0, acc1;
  bit          order[$];

  task automatic model_reset();
    m_out = 1'b0; m_prio = 1'b0; m_alu = '0; m_exp = '0;
  endtask

  task automatic step_chk();
    bit   e0, e1, erv;
    pay_t pay;
    @(negedge clk);
    e0  = !m_out && req0_valid && (!req1_valid || !m_prio);
    e1  = !m_out && req1_valid && (!req0_valid ||  m_prio);
    erv = m_out && (cyc >= m_resp_at);
    check("req0_ready", CW'(req0_ready), CW'(e0));
    check("req1_ready", CW'(req1_ready), CW'(e1));
    check("rsp_valid",  CW'(rsp_valid),  CW'(erv));
    check("busy",       CW'(busy),       CW'(m_out));
    check("alu_op1",    CW'(alu_op1),    CW'(m_alu.op1));
    check("alu_op2",    CW'(alu_op2),    CW'(m_alu.op2));
    check("alu_ctl",    CW'({alu_opsel, alu_mode}), CW'({m_alu.opsel, m_alu.mode}));
    if (erv)
      check("rsp_payload",
            CW'({rsp_id, rsp_err, rsp_c, rsp_z, rsp_o, rsp_s, rsp_result}), m_exp);
    acc0 = e0; acc1 = e1;
    if (erv && rsp_ready) begin
      m_out  = 1'b0;
      m_prio = ~m_exp[CW-1];
    end
    if (e0 || e1) begin
      pay   = e1 ? p1 : p0;
      m_out = 1'b1;
      order.push_back(e1);
      if (is_illegal(pay)) begin
        m_resp_at = cyc + 1;
        m_exp     = {e1, 1'b1, 4'b0000, W'(0)};
      end else begin
        m_resp_at = cyc + int'(LAT) + 1;
        m_exp     = {e1, 1'b0, alu_fn(pay.op1, pay.op2, pay.opsel, pay.mode)};
        m_alu     = pay;
      end
    end
  endtask

  task automatic step_adv();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic step();
    step_chk();
    step_adv();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_req0_ready", CW'(req0_ready), CW'(0));
    check("rst_req1_ready", CW'(req1_ready), CW'(0));
    check("rst_rsp_valid",  CW'(rsp_valid),  CW'(0));
    check("rst_busy",       CW'(busy),       CW'(0));
    check("rst_alu_op1",    CW'(alu_op1),    CW'(0));
    check("rst_rsp",        CW'({rsp_id, rsp_err, rsp_c, rsp_z, rsp_o, rsp_s, rsp_result}), CW'(0));
    check("rst_b_ready",    CW'(b_r0),       CW'(0));
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    cyc++;
  endtask

  task automatic drain();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    for (int k = 0; k < 30 && m_out; k++) step();
    check("drain_timeout", CW'(m_out), CW'(0));
  endtask

  pay_t fixed;
  logic [W-1:0] saved_op1;

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    p0 = rand_pay(); p1 = rand_pay();
    b_v0 = 1'b1; b_pay = '0;
    fixed = '0; fixed.op1 = W'(5); fixed.op2 = W'(7);
    do_reset();

    // ALU_LAT=4 instance: inputs held T+1..T+4, response in T+5
    req0_valid = 1'b0; req1_valid = 1'b0;
    b_v0 = 1'b1; b_pay = fixed;
    step_chk();
    check("b_ready_T", CW'(b_r0), CW'(1));
    step_adv();
    b_v0 = 1'b0; b_pay = rand_pay();
    for (int k = 1; k <= 4; k++) begin
      step_chk();
      check("b_alu_op1_hold", CW'(b_alu_op1), CW'(5));
      check("b_alu_op2_hold", CW'(b_alu_op2), CW'(7));
      check("b_rsp_valid_lo", CW'(b_rsp_valid), CW'(0));
      check("b_busy_wait",    CW'(b_busy), CW'(1));
      step_adv();
    end
    step_chk();
    check("b_rsp_valid_T5", CW'(b_rsp_valid), CW'(1));
    check("b_rsp_result",   CW'(b_rsp_result), CW'(12));
    check("b_rsp_id",       CW'(b_rsp_id), CW'(0));
    step_adv();
    step_chk();
    check("b_idle_after", CW'({b_rsp_valid, b_busy}), CW'(0));
    step_adv();

    // Contention from reset: order 0,1,0,1
    req0_valid = 1'b1; req1_valid = 1'b1; p0 = rand_pay(); p1 = rand_pay();
    do_reset();
    order.delete();
    for (int k = 0; k < 40 && order.size() < 4; k++) begin
      step();
      if (acc0) p0 = rand_pay();
      if (acc1) p1 = rand_pay();
    end
    check("contention_count", CW'(order.size() >= 4), CW'(1));
    check("order0", CW'(order[0]), CW'(0));
    check("order1", CW'(order[1]), CW'(1));
    check("order2", CW'(order[2]), CW'(0));
    check("order3", CW'(order[3]), CW'(1));
    drain();

    // Single op: 5 + 7 on req0
    p0 = fixed; req0_valid = 1'b1;
    step_chk();
    check("single_ready_T", CW'(req0_ready), CW'(1));
    step_adv();
    req0_valid = 1'b0;
    step();
    step_chk();
    check("single_valid_T2", CW'(rsp_valid), CW'(1));
    check("single_result",   CW'(rsp_result), CW'(12));
    check("single_id",       CW'(rsp_id), CW'(0));
    check("single_z",        CW'(rsp_z), CW'(0));
    step_adv();
    step();

    // Backpressure: rsp_ready low for 5 cycles while req0 waits
    p0 = rand_pay(); p0.mode = 1'b0; p0.opsel = 3'd0;
    p1 = rand_pay(); p1.mode = 1'b0; p1.opsel = 3'd1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    step_chk();
    check("bp_grant_req1", CW'(req1_ready), CW'(1));
    step_adv();
    req1_valid = 1'b0;
    step();
    for (int k = 0; k < 5; k++) step();
    rsp_ready = 1'b1;
    step_chk();
    check("bp_valid_at_release", CW'(rsp_valid), CW'(1));
    step_adv();
    step_chk();
    check("bp_next_req0", CW'(req0_ready), CW'(1));
    step_adv();
    drain();

    // Reset during WAIT: op discarded, pointer back to req0
    p1 = rand_pay(); p1.mode = 1'b0; p1.opsel = 3'd0;
    req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_busy",  CW'(busy), CW'(0));
    check("midrst_valid", CW'(rsp_valid), CW'(0));
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    cyc++;
    p0 = rand_pay(); p1 = rand_pay();
    req0_valid = 1'b1; req1_valid = 1'b1;
    step_chk();
    check("midrst_grant_req0", CW'({req0_ready, req1_ready}), CW'(2'b10));
    step_adv();
    drain();

`ifdef ALU_ARB_OPCHECK_EN
    // Illegal op on req1: immediate error response, ALU untouched
    saved_op1 = alu_op1;
    p1 = rand_pay(); p1.mode = 1'b1; p1.opsel = 3'b110;
    req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    step_chk();
    check("ill_valid_T1", CW'(rsp_valid), CW'(1));
    check("ill_err",      CW'(rsp_err), CW'(1));
    check("ill_result",   CW'(rsp_result), CW'(0));
    check("ill_id",       CW'(rsp_id), CW'(1));
    check("ill_alu_held", CW'(alu_op1), CW'(saved_op1));
    step_adv();
    drain();
`else
    saved_op1 = '0;
`endif

    // Randomized traffic with random backpressure
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (acc0 || !req0_valid) begin
        req0_valid = 1'($urandom_range(0, 1));
        p0 = rand_pay();
      end
      if (acc1 || !req1_valid) begin
        req1_valid = 1'($urandom_range(0, 1));
        p1 = rand_pay();
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
